// File: rtl/output_channel_buffer_if.sv
// TIA channel types and the two port bundles used by the output channel buffer:
// the PE-facing output channel and the outgoing req/ack link.

package tia_pkg;
  parameter int unsigned TIA_CHANNEL_BUFFER_FIFO_DEPTH = 4;
  parameter int unsigned PacketWidth = 16;

  typedef logic [PacketWidth-1:0] packet_t;
endpackage

// PE-to-buffer enqueue port. The buffer is the receiver; the PE is the sender.
interface output_channel_if #(
  parameter int unsigned FIFO_DEPTH = tia_pkg::TIA_CHANNEL_BUFFER_FIFO_DEPTH
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  tia_pkg::packet_t      packet;
  logic                  enqueue;
  logic                  full;
  logic [CountWidth-1:0] count;

  modport receiver (
    input  packet,
    input  enqueue,
    output full,
    output count
  );

  modport sender (
    output packet,
    output enqueue,
    input  full,
    input  count
  );
endinterface

// Point-to-point req/ack link. A transfer completes on an edge where req and ack are both high.
interface link_if;
  tia_pkg::packet_t packet;
  logic             req;
  logic             ack;

  modport sender (
    output packet,
    output req,
    input  ack
  );

  modport receiver (
    input  packet,
    input  req,
    output ack
  );
endinterface

// File: rtl/output_channel_buffer.sv
// Transmit-side channel buffer: queues packets from the PE and offers the oldest one on the
// outgoing link, popping it only on a completed req/ack transfer.

module output_channel_buffer
  import tia_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = TIA_CHANNEL_BUFFER_FIFO_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  output_channel_if.receiver        output_channel,
  link_if.sender                    link,
  output logic                      overflow,
  output logic                      quiescent
);

  localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountWidth = PtrWidth + 1;
  localparam logic [CountWidth-1:0] CountFull = CountWidth'(FIFO_DEPTH);

  // Pointer arithmetic relies on natural wrap, so the depth must be a power of two.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("output_channel_buffer: FIFO_DEPTH must be a power of two >= 2");
  end

  packet_t               fifo_q [FIFO_DEPTH];
  logic [PtrWidth-1:0]   head_q, head_d;
  logic [PtrWidth-1:0]   tail_q, tail_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic not_empty;
  logic is_full;
  logic req;
  logic acc;
  logic xfer;
  logic reject;

  // Handshake decode; everything is derived from the pre-edge count, so ack never reaches
  // req or full combinationally and a same-cycle pop cannot make room for an enqueue.
  always_comb begin
    not_empty = (count_q != '0);
    is_full   = (count_q == CountFull);
    req       = enable && not_empty;
    acc       = enable && output_channel.enqueue && !is_full;
    reject    = enable && output_channel.enqueue && is_full;
    xfer      = req && link.ack;
  end

  // Output drive.
  always_comb begin
    link.packet          = fifo_q[head_q];
    link.req             = req;
    output_channel.full  = is_full;
    output_channel.count = count_q;
    overflow             = overflow_q;
    quiescent            = !not_empty;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (acc) begin
      tail_d = tail_q + PtrWidth'(1);
    end
    if (xfer) begin
      head_d = head_q + PtrWidth'(1);
    end

    case ({acc, xfer})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase

    if (reject) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with synchronous reset; disabled cycles hold because acc/xfer are low.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Packet storage is deliberately not reset; only slots between head and tail are meaningful.
  always_ff @(posedge clock) begin
    if (!reset && acc) begin
      fifo_q[tail_q] <= output_channel.packet;
    end
  end

  // Occupancy never exceeds the number of slots.
  a_count_range: assert property (@(posedge clock) disable iff (reset)
    count_q <= CountFull);

  // A stalled offer must not change under the receiver.
  a_stall_stable: assert property (@(posedge clock) disable iff (reset)
    (req && !link.ack) |=> $stable(link.packet));

endmodule

// File: tb/tb_output_channel_buffer.sv
// Directed and randomized bench for output_channel_buffer (depth 4) against a queue model.

module tb_output_channel_buffer;
  import tia_pkg::*;

  localparam int unsigned Depth = 4;

  logic clock;
  logic reset;
  logic enable;
  logic overflow;
  logic quiescent;

  output_channel_if #(.FIFO_DEPTH(Depth)) oc ();
  link_if lk ();

  output_channel_buffer #(.FIFO_DEPTH(Depth)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .output_channel (oc.receiver),
    .link           (lk.sender),
    .overflow       (overflow),
    .quiescent      (quiescent)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Reference model: plain queue plus sticky flag.
  packet_t mq[$];
  bit      m_ovf;
  packet_t xfer_log[$];
  packet_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, log transfers, advance model.
  task automatic step(input bit en, input bit enq, input packet_t pkt, input bit ack,
                      input bit rst = 1'b0);
    bit m_req, m_acc, m_xfer;
    reset      = rst;
    enable     = en;
    oc.enqueue = enq;
    oc.packet  = pkt;
    lk.ack     = ack;
    #1;
    m_req = en && (mq.size() != 0);
    chk("req", 32'(lk.req), 32'(m_req));
    chk("count", 32'(oc.count), mq.size());
    chk("full", 32'(oc.full), 32'(mq.size() == Depth));
    chk("quiescent", 32'(quiescent), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk("packet", 32'(lk.packet), 32'(mq[0]));
    if (lk.req === 1'b1 && lk.ack === 1'b1) xfer_log.push_back(lk.packet);

    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_acc  = en && enq && (mq.size() < Depth);
      m_xfer = m_req && ack;
      if (en && enq && mq.size() == Depth) m_ovf = 1'b1;
      if (m_xfer) void'(mq.pop_front());
      if (m_acc) mq.push_back(pkt);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, xfer_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < xfer_log.size(); i++) begin
      chk(tag, 32'(xfer_log[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    oc.enqueue = 1'b0;
    oc.packet  = '0;
    lk.ack     = 1'b0;
    m_ovf      = 1'b0;
    @(posedge clock);
    @(negedge clock);

    // Reset state, then three enqueues held with ack low.
    step(1, 0, 16'h0, 0, 1);
    step(1, 1, 16'hA1, 0);
    step(1, 1, 16'hA2, 0);
    step(1, 1, 16'hA3, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0);
    chk("s1_packet", 32'(lk.packet), 32'h00A1);
    chk("s1_count", 32'(oc.count), 32'd3);

    // Fill, overflow on a fifth enqueue, then drain.
    step(1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, packet_t'(16'h10 + i), 0);
    chk("s2_full", 32'(oc.full), 32'd1);
    chk("s2_ovf", 32'(overflow), 32'd1);
    xfer_log.delete();
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 0);
    exp_q = '{16'h10, 16'h11, 16'h12, 16'h13};
    check_log("s2_order");

    // Streaming with ack held high across several pointer wraps.
    step(1, 0, 16'h0, 0, 1);
    xfer_log.delete();
    for (int i = 0; i < 12; i++) step(1, 1, packet_t'(16'h20 + i), 1);
    step(1, 0, 16'h0, 1);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(packet_t'(16'h20 + i));
    check_log("s3_stream");

    // Enqueue while full is rejected even though a transfer frees a slot; retry succeeds.
    step(1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, packet_t'(16'h40 + i), 0);
    step(1, 1, 16'h30, 1);
    chk("s4_count_after_reject", 32'(oc.count), 32'd3);
    step(1, 1, 16'h30, 0);
    chk("s4_count_after_retry", 32'(oc.count), 32'd4);
    chk("s4_ovf", 32'(overflow), 32'd1);

    // Disabled cycles hold everything, then transfers resume in order.
    step(1, 0, 16'h0, 0, 1);
    step(1, 1, 16'h61, 0);
    step(1, 1, 16'h62, 0);
    xfer_log.delete();
    for (int i = 0; i < 3; i++) step(0, 1, 16'h6F, 1);
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 0);
    exp_q = '{16'h61, 16'h62};
    check_log("s5_resume");

    // Reset mid-operation discards queued packets.
    step(1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, packet_t'(16'h70 + i), 0);
    step(1, 0, 16'h0, 1, 1);
    xfer_log.delete();
    step(1, 1, 16'h55, 1);
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 0);
    exp_q = '{16'h55};
    check_log("s6_first_after_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, packet_t'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
